// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared encodings for the multicycle MIPS control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    localparam int ST_W = 4;

    // Fixed encoding; o_state exposes these values directly for debug.
    typedef enum logic [ST_W-1:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_JUMP   = 4'd11,
        ST_IDLE   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
// ============================================================================
// Module      : multicycle_ctrl_decode
// Description : Pure combinational state-to-control-vector decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t i_state,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.alu_src_b = ALUSRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_src    = PCSRC_ALU;
            end
            ST_DECODE: begin
                o_ctrl.alu_src_b = ALUSRCB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUSRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            ST_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            ST_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = ALUSRCB_B;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = ALUSRCB_B;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_src        = PCSRC_ALUOUT;
            end
            ST_ADDIWB: begin
                o_ctrl.reg_write = 1'b1;
            end
            ST_JUMP: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = PCSRC_JUMP;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM for the multicycle MIPS datapath.
//               Define MULTICYCLE_CTRL_MEMWAIT_EN to stall memory states on i_memReady.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [5:0]         i_opcode,
    input  logic               i_memReady,
    output logic               o_pcWrite,
    output logic               o_pcWriteCond,
    output logic               o_iorD,
    output logic               o_memRead,
    output logic               o_memWrite,
    output logic               o_irWrite,
    output logic               o_memToReg,
    output logic               o_regDst,
    output logic               o_regWrite,
    output logic               o_aluSrcA,
    output logic [1:0]         o_aluSrcB,
    output logic [1:0]         o_pcSrc,
    output logic [1:0]         o_aluOp,
    output logic               o_illegal,
    output logic [STATE_W-1:0] o_state
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;
    logic   w_mem_ready;
    logic   w_fetch_hold;

`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    assign w_mem_ready = i_memReady;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = i_memReady;
    assign w_mem_ready        = 1'b1;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next_state = ST_FETCH;
            ST_FETCH:  w_next_state = w_mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: w_next_state = ST_MEMADR;
                    OP_RTYPE:     w_next_state = ST_EXEC;
                    OP_BEQ:       w_next_state = ST_BRANCH;
                    OP_ADDI:      w_next_state = ST_ADDIEX;
                    OP_J:         w_next_state = ST_JUMP;
                    default:      w_next_state = ST_FETCH;
                endcase
            end
            ST_MEMADR: w_next_state = (i_opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  w_next_state = w_mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  w_next_state = ST_FETCH;
            ST_MEMWR:  w_next_state = w_mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   w_next_state = ST_ALUWB;
            ST_ALUWB:  w_next_state = ST_FETCH;
            ST_BRANCH: w_next_state = ST_FETCH;
            ST_ADDIEX: w_next_state = ST_ADDIWB;
            ST_ADDIWB: w_next_state = ST_FETCH;
            ST_JUMP:   w_next_state = ST_FETCH;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .i_state (r_state),
        .o_ctrl  (w_ctrl)
    );

    // PC and IR must only load on the cycle the fetched word is actually valid.
    assign w_fetch_hold = (r_state == ST_FETCH) && !w_mem_ready;

    assign o_pcWrite     = w_ctrl.pc_write & ~w_fetch_hold;
    assign o_irWrite     = w_ctrl.ir_write & ~w_fetch_hold;
    assign o_pcWriteCond = w_ctrl.pc_write_cond;
    assign o_iorD        = w_ctrl.iord;
    assign o_memRead     = w_ctrl.mem_read;
    assign o_memWrite    = w_ctrl.mem_write;
    assign o_memToReg    = w_ctrl.mem_to_reg;
    assign o_regDst      = w_ctrl.reg_dst;
    assign o_regWrite    = w_ctrl.reg_write;
    assign o_aluSrcA     = w_ctrl.alu_src_a;
    assign o_aluSrcB     = w_ctrl.alu_src_b;
    assign o_pcSrc       = w_ctrl.pc_src;
    assign o_aluOp       = w_ctrl.alu_op;
    assign o_illegal     = (r_state == ST_DECODE) && !is_legal_op(i_opcode);
    assign o_state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module      : tb_multicycle_control
// Description : Randomized self-checking bench with a per-instruction step model.
//               Honours MULTICYCLE_CTRL_MEMWAIT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    localparam bit WAIT = 1'b1;
`else
    localparam bit WAIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src, alu_op;
    logic [3:0] state;

    multicycle_control #(.STATE_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_memReady(mem_ready),
        .o_pcWrite(pc_write), .o_pcWriteCond(pc_write_cond), .o_iorD(iord),
        .o_memRead(mem_read), .o_memWrite(mem_write), .o_irWrite(ir_write),
        .o_memToReg(mem_to_reg), .o_regDst(reg_dst), .o_regWrite(reg_write),
        .o_aluSrcA(alu_src_a), .o_aluSrcB(alu_src_b), .o_pcSrc(pc_src),
        .o_aluOp(alu_op), .o_illegal(illegal), .o_state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        bit rdy;
        bit ill;
    } step_t;

    step_t      q[$];
    int         total = 0;
    int         bad   = 0;
    logic [5:0] cur_op;
    int         n_nonfetch, n_fetch, n_ill, n_regw, n_memw, n_pcw_fetch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
    endfunction

    // Controls required in a given step, in the order of out_vec().
    function automatic logic [15:0] exp_vec(input int st, input bit rdy);
        bit pcw = 0, pcwc = 0, io = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00, ao = 2'b00;
        case (st)
            0:  begin mr = 1; sb = 2'b01; pcw = WAIT ? rdy : 1'b1; irw = pcw; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mr = 1; io = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; io = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, ps, ao};
    endfunction

    function automatic logic [15:0] out_vec();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_src, alu_op};
    endfunction

    function automatic void push(input int st, input bit rdy, input bit ill);
        step_t s;
        s.st = st; s.rdy = rdy; s.ill = ill;
        q.push_back(s);
    endfunction

    function automatic bit rnd();
        return 1'($urandom);
    endfunction

    // Memory-facing step: stalls only exist when the wait feature is built in.
    function automatic void push_mem(input int st, input int n);
        if (WAIT) for (int i = 0; i < n; i++) push(st, 1'b0, 1'b0);
        push(st, WAIT ? 1'b1 : rnd(), 1'b0);
    endfunction

    function automatic void plan(input logic [5:0] op, input int fs, input int ms);
        push_mem(0, fs);
        push(1, rnd(), !legal(op));
        case (op)
            6'b100011: begin push(2, rnd(), 0); push_mem(3, ms); push(4, rnd(), 0); end
            6'b101011: begin push(2, rnd(), 0); push_mem(5, ms); end
            6'b000000: begin push(6, rnd(), 0); push(7, rnd(), 0); end
            6'b000100: push(8, rnd(), 0);
            6'b001000: begin push(9, rnd(), 0); push(10, rnd(), 0); end
            6'b000010: push(11, rnd(), 0);
            default: ;
        endcase
    endfunction

    task automatic run_steps(input int n);
        for (int i = 0; i < n && q.size() > 0; i++) begin
            @(negedge clk);
            opcode    = cur_op;
            mem_ready = q[0].rdy;
            #1;
            chk("state", 32'(state), 32'(q[0].st));
            chk("ctrl", 32'(out_vec()), 32'(exp_vec(q[0].st, q[0].rdy)));
            chk("illegal", 32'(illegal), 32'(q[0].ill));
            if (state != 4'd0) n_nonfetch++;
            else begin
                n_fetch++;
                if (pc_write) n_pcw_fetch++;
            end
            if (illegal)   n_ill++;
            if (reg_write) n_regw++;
            if (mem_write) n_memw++;
            void'(q.pop_front());
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int fs, input int ms);
        n_nonfetch = 0; n_fetch = 0; n_ill = 0; n_regw = 0; n_memw = 0; n_pcw_fetch = 0;
        cur_op = op;
        plan(op, fs, ms);
        run_steps(1000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [6];
        ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
        opcode = 6'b000010; mem_ready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'd15);
        chk("rst_ctrl", 32'(out_vec()), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("first_fetch_state", 32'(state), 32'd0);
        chk("first_fetch_memread", 32'(mem_read), 32'd1);
        chk("first_fetch_irwrite", 32'(ir_write), 32'd1);
        chk("first_fetch_pcwrite", 32'(pc_write), 32'd1);
        chk("first_fetch_aluop", 32'(alu_op), 32'd0);
        cur_op = 6'b000010;
        plan(cur_op, 0, 0);
        void'(q.pop_front());
        run_steps(1000);

        // Directed instructions with literal cycle counts.
        run_instr(6'b100011, 0, 0); chk("lw_cycles",   32'(n_nonfetch + 1), 32'd5);
        run_instr(6'b101011, 0, 0); chk("sw_cycles",   32'(n_nonfetch + 1), 32'd4);
        run_instr(6'b000000, 0, 0); chk("r_cycles",    32'(n_nonfetch + 1), 32'd4);
        run_instr(6'b001000, 0, 0); chk("addi_cycles", 32'(n_nonfetch + 1), 32'd4);
        run_instr(6'b000100, 0, 0); chk("beq_cycles",  32'(n_nonfetch + 1), 32'd3);
        run_instr(6'b000010, 0, 0); chk("j_cycles",    32'(n_nonfetch + 1), 32'd3);
        run_instr(6'b111111, 0, 0);
        chk("ill_cycles", 32'(n_nonfetch + 1), 32'd2);
        chk("ill_pulses", 32'(n_ill), 32'd1);
        chk("ill_regwrite", 32'(n_regw), 32'd0);
        chk("ill_memwrite", 32'(n_memw), 32'd0);

        if (WAIT) begin
            run_instr(6'b000010, 3, 0);
            chk("stall_fetch_cycles", 32'(n_fetch), 32'd4);
            chk("stall_fetch_pcwrite", 32'(n_pcw_fetch), 32'd1);
            run_instr(6'b101011, 0, 3);
            chk("stall_sw_memwrite", 32'(n_memw), 32'd4);
        end

        for (int k = 0; k < 250; k++) begin
            logic [5:0] op;
            int sel;
            sel = int'($urandom_range(0, 7));
            op  = (sel < 6) ? ops[sel] : 6'($urandom);
            run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Abort an lw once it has reached the memory read.
        cur_op = 6'b100011;
        plan(cur_op, 0, 0);
        run_steps(3);
        q.delete();
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("abort_pre_state", 32'(state), 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("abort_state", 32'(state), 32'd15);
        chk("abort_ctrl", 32'(out_vec()), 32'd0);
        @(negedge clk);
        #1;
        chk("abort_hold_state", 32'(state), 32'd15);
        chk("abort_hold_ctrl", 32'(out_vec()), 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 40; k++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 5)];
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
